// File: rtl/noc_switch_allocator.sv
// Per-output round-robin switch allocator with packet locking; grants are combinational (zero latency).
// A full downstream FIFO blocks its output only; an unlocked stalled output keeps no memory of the stalled grant.
module noc_switch_allocator #(
  parameter int RADIX_IN   = 4,
  parameter int RADIX_OUT  = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int SEL_WIDTH  = (RADIX_IN > 1) ? $clog2(RADIX_IN) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [RADIX_IN-1:0]            req_valid,
  input  logic [RADIX_IN*ADDR_WIDTH-1:0] req_dest,
  input  logic [RADIX_IN-1:0]            req_last,
  output logic [RADIX_IN-1:0]            req_deq,
  input  logic [RADIX_OUT-1:0]           FIFO_FULL_downstream,
  output logic [RADIX_OUT-1:0]           FIFO_ENQ_downstream,
  output logic [RADIX_OUT*SEL_WIDTH-1:0] xbar_sel,
  output logic [RADIX_OUT-1:0]           out_locked,
  output logic [RADIX_IN-1:0]            dest_err
);

  logic [RADIX_OUT-1:0]  r_locked;
  logic [SEL_WIDTH-1:0]  r_owner  [RADIX_OUT];
  logic [SEL_WIDTH-1:0]  r_rr_ptr [RADIX_OUT];

  logic [ADDR_WIDTH-1:0] w_dest   [RADIX_IN];
  logic [RADIX_OUT-1:0]  w_req    [RADIX_IN];
  logic [RADIX_IN-1:0]   w_bad;
  logic [RADIX_OUT-1:0]  w_found;
  logic [RADIX_OUT-1:0]  w_xfer;
  logic [SEL_WIDTH-1:0]  w_cand   [RADIX_OUT];

  for (genvar gi = 0; gi < RADIX_IN; gi++) begin : g_dest
    assign w_dest[gi] = req_dest[gi*ADDR_WIDTH +: ADDR_WIDTH];
  end

  always_comb begin
    for (int i = 0; i < RADIX_IN; i++) begin
      w_bad[i] = int'(w_dest[i]) >= RADIX_OUT;
      for (int o = 0; o < RADIX_OUT; o++) begin
        w_req[i][o] = req_valid[i] && (int'(w_dest[i]) == o);
      end
    end
  end

  // A locked output only listens to its owner; otherwise scan from the round-robin pointer.
  always_comb begin
    int v_idx;
    v_idx = 0;
    for (int o = 0; o < RADIX_OUT; o++) begin
      w_found[o] = 1'b0;
      w_cand[o]  = '0;
      if (r_locked[o]) begin
        w_found[o] = w_req[r_owner[o]][o];
        w_cand[o]  = r_owner[o];
      end else begin
        for (int k = 0; k < RADIX_IN; k++) begin
          v_idx = (int'(r_rr_ptr[o]) + k) % RADIX_IN;
          if (!w_found[o] && w_req[v_idx][o]) begin
            w_found[o] = 1'b1;
            w_cand[o]  = SEL_WIDTH'(v_idx);
          end
        end
      end
      w_xfer[o] = w_found[o] && !FIFO_FULL_downstream[o] && !rst;
    end
  end

  always_comb begin
    req_deq             = '0;
    xbar_sel            = '0;
    FIFO_ENQ_downstream = w_xfer;
    for (int o = 0; o < RADIX_OUT; o++) begin
      if (w_xfer[o]) begin
        req_deq[w_cand[o]] = 1'b1;
      end
      if (!rst) begin
        xbar_sel[o*SEL_WIDTH +: SEL_WIDTH] = w_xfer[o]   ? w_cand[o]  :
                                             r_locked[o] ? r_owner[o] : r_rr_ptr[o];
      end
    end
    out_locked = rst ? '0 : r_locked;
    dest_err   = rst ? '0 : (req_valid & w_bad);
  end

  // Tail releases the output and advances the pointer past the winner; body flits lock it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_locked <= '0;
      for (int o = 0; o < RADIX_OUT; o++) begin
        r_owner[o]  <= '0;
        r_rr_ptr[o] <= '0;
      end
    end else begin
      for (int o = 0; o < RADIX_OUT; o++) begin
        if (w_xfer[o]) begin
          if (req_last[w_cand[o]]) begin
            r_locked[o] <= 1'b0;
            r_rr_ptr[o] <= SEL_WIDTH'((int'(w_cand[o]) + 1) % RADIX_IN);
          end else begin
            r_locked[o] <= 1'b1;
            r_owner[o]  <= w_cand[o];
          end
        end
      end
    end
  end

endmodule
